// File: rtl/stopwatch_core.sv
// stopwatch_core: MM:SS BCD stopwatch timing core.
// Loads a four-digit BCD preset, counts seconds up to 59:59 or down to 00:00
// under load/stop/start control, and pulses done on reaching the terminal value.
// Optional lap capture registers are built when STOPWATCH_LAP_EN is defined.
module stopwatch_core #(
    parameter int TICKS_PER_SEC = 50_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic [3:0] C,
    input  logic [3:0] D,
    input  logic       load,
    input  logic       start,
    input  logic       stop,
    input  logic       down,
    output logic [3:0] M1,
    output logic [3:0] M0,
    output logic [3:0] S1,
    output logic [3:0] S0,
    output logic       running,
    output logic       done,
    output logic       err
`ifdef STOPWATCH_LAP_EN
    ,
    input  logic       lap,
    output logic [3:0] LM1,
    output logic [3:0] LM0,
    output logic [3:0] LS1,
    output logic [3:0] LS0
`endif
);

    localparam int PW = $clog2(TICKS_PER_SEC);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);
    localparam logic [15:0] DIG_MAX  = 16'h5959;
    localparam logic [15:0] DIG_ZERO = 16'h0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic [15:0]     cnt_q, cnt_d;          // {M1, M0, S1, S0}
    logic [PW-1:0]   presc_q, presc_d;
    logic            dir_q, dir_d;          // 1 = counting down
    logic            running_q, running_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic [15:0]     step_s;
    logic            start_term_s;
`ifdef STOPWATCH_LAP_EN
    logic [15:0]     lap_q, lap_d;
`endif

    // A preset is usable only if every digit is a legal MM:SS BCD digit.
    function automatic logic preset_ok(input logic [3:0] a, input logic [3:0] b,
                                       input logic [3:0] c, input logic [3:0] d);
        return (a <= 4'd5) && (b <= 4'd9) && (c <= 4'd5) && (d <= 4'd9);
    endfunction

    // One-second BCD increment; never called on 59:59 so M1 cannot overflow.
    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [3:0] m1, m0, s1, s0;
        {m1, m0, s1, s0} = v;
        if (s0 != 4'd9) begin
            s0 = s0 + 4'd1;
        end else begin
            s0 = 4'd0;
            if (s1 != 4'd5) begin
                s1 = s1 + 4'd1;
            end else begin
                s1 = 4'd0;
                if (m0 != 4'd9) begin
                    m0 = m0 + 4'd1;
                end else begin
                    m0 = 4'd0;
                    m1 = m1 + 4'd1;
                end
            end
        end
        return {m1, m0, s1, s0};
    endfunction

    // One-second BCD decrement; never called on 00:00 so M1 cannot underflow.
    function automatic logic [15:0] bcd_dec(input logic [15:0] v);
        logic [3:0] m1, m0, s1, s0;
        {m1, m0, s1, s0} = v;
        if (s0 != 4'd0) begin
            s0 = s0 - 4'd1;
        end else begin
            s0 = 4'd9;
            if (s1 != 4'd0) begin
                s1 = s1 - 4'd1;
            end else begin
                s1 = 4'd5;
                if (m0 != 4'd0) begin
                    m0 = m0 - 4'd1;
                end else begin
                    m0 = 4'd9;
                    m1 = m1 - 4'd1;
                end
            end
        end
        return {m1, m0, s1, s0};
    endfunction

    // Next-state, digit, prescaler and pulse logic for the control FSM.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        presc_d   = presc_q;
        dir_d     = dir_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        step_s    = dir_q ? bcd_dec(cnt_q) : bcd_inc(cnt_q);
        start_term_s = down ? (cnt_q == DIG_ZERO) : (cnt_q == DIG_MAX);

        case (state_q)
            ST_RUN: begin
                // load is not honoured while counting; stop beats a same-cycle tick
                if (stop) begin
                    state_d = ST_PAUSE;
                end else if (presc_q == PRESC_LAST) begin
                    presc_d = '0;
                    cnt_d   = step_s;
                    if (step_s == (dir_q ? DIG_ZERO : DIG_MAX)) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else begin
                    presc_d = presc_q + PW'(1);
                end
            end
            ST_IDLE, ST_PAUSE, ST_DONE: begin
                if (load) begin
                    if (preset_ok(A, B, C, D)) begin
                        cnt_d   = {A, B, C, D};
                        presc_d = '0;
                        state_d = ST_IDLE;
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (stop) begin
                    // stop outranks start; nothing to pause outside RUN
                    state_d = state_q;
                end else if (start && (state_q != ST_DONE)) begin
                    presc_d = '0;
                    dir_d   = down;
                    if (start_term_s) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        running_d = (state_d == ST_RUN);
    end

    // State, digit, prescaler and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 16'h0000;
            presc_q   <= '0;
            dir_q     <= 1'b0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            presc_q   <= presc_d;
            dir_q     <= dir_d;
            running_q <= running_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign {M1, M0, S1, S0} = cnt_q;
    assign running = running_q;
    assign done    = done_q;
    assign err     = err_q;

`ifdef STOPWATCH_LAP_EN
    // Lap capture: snapshot the live digits only while counting.
    always_comb begin
        if ((state_q == ST_RUN) && lap) begin
            lap_d = cnt_q;
        end else begin
            lap_d = lap_q;
        end
    end

    // Lap register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lap_q <= 16'h0000;
        end else begin
            lap_q <= lap_d;
        end
    end

    assign {LM1, LM0, LS1, LS0} = lap_q;
`endif

endmodule

// File: tb/tb_stopwatch_core.sv
// Directed self-checking bench for stopwatch_core with TICKS_PER_SEC = 4.
// Lap scenario is compiled in when STOPWATCH_LAP_EN is defined.
module tb_stopwatch_core;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] A = 4'd0, B = 4'd0, C = 4'd0, D = 4'd0;
    logic       load = 1'b0, start = 1'b0, stop = 1'b0, down = 1'b0;
    logic [3:0] M1, M0, S1, S0;
    logic       running, done, err;
    logic [15:0] dig;
`ifdef STOPWATCH_LAP_EN
    logic       lap = 1'b0;
    logic [3:0] LM1, LM0, LS1, LS0;
    logic [15:0] lapv;
    assign lapv = {LM1, LM0, LS1, LS0};
`endif

    int tests_run = 0;
    int tests_failed = 0;

    assign dig = {M1, M0, S1, S0};

    stopwatch_core #(.TICKS_PER_SEC(4)) dut (
        .clk(clk), .reset(reset),
        .A(A), .B(B), .C(C), .D(D),
        .load(load), .start(start), .stop(stop), .down(down),
        .M1(M1), .M0(M0), .S1(S1), .S0(S0),
        .running(running), .done(done), .err(err)
`ifdef STOPWATCH_LAP_EN
        , .lap(lap), .LM1(LM1), .LM0(LM0), .LS1(LS1), .LS0(LS0)
`endif
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_load(input logic [15:0] v);
        {A, B, C, D} = v;
        load = 1'b1;
        step(1);
        load = 1'b0;
    endtask

    task automatic do_start(input logic dn);
        down = dn;
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    task automatic test_reset;
        step(2);
        tests_run++; if (dig !== 16'h0000) begin tests_failed++; $display("FAIL rst_dig got %h exp 0000", dig); end
        tests_run++; if ({running, done, err} !== 3'b000) begin tests_failed++; $display("FAIL rst_flags got %b exp 000", {running, done, err}); end
        reset = 1'b1;
        step(1);
    endtask

    task automatic test_count_down;
        do_load(16'h0003);
        tests_run++; if (dig !== 16'h0003) begin tests_failed++; $display("FAIL dn_load got %h exp 0003", dig); end
        do_start(1'b1);
        tests_run++; if (running !== 1'b1) begin tests_failed++; $display("FAIL dn_running got %b exp 1", running); end
        step(3);
        tests_run++; if (dig !== 16'h0003) begin tests_failed++; $display("FAIL dn_hold3 got %h exp 0003", dig); end
        step(1);
        tests_run++; if (dig !== 16'h0002) begin tests_failed++; $display("FAIL dn_4 got %h exp 0002", dig); end
        step(4);
        tests_run++; if (dig !== 16'h0001) begin tests_failed++; $display("FAIL dn_8 got %h exp 0001", dig); end
        step(3);
        tests_run++; if (done !== 1'b0) begin tests_failed++; $display("FAIL dn_early_done got %b exp 0", done); end
        step(1);
        tests_run++; if (dig !== 16'h0000) begin tests_failed++; $display("FAIL dn_12 got %h exp 0000", dig); end
        tests_run++; if ({running, done} !== 2'b01) begin tests_failed++; $display("FAIL dn_done got run/done %b exp 01", {running, done}); end
        step(1);
        tests_run++; if (done !== 1'b0) begin tests_failed++; $display("FAIL dn_done_pulse got %b exp 0", done); end
    endtask

    task automatic test_carry;
        do_load(16'h0059);
        do_start(1'b0);
        step(4);
        tests_run++; if (dig !== 16'h0100) begin tests_failed++; $display("FAIL carry got %h exp 0100", dig); end
        tests_run++; if (running !== 1'b1) begin tests_failed++; $display("FAIL carry_run got %b exp 1", running); end
    endtask

    task automatic test_up_done;
        stop = 1'b1; step(1); stop = 1'b0;
        do_load(16'h5958);
        do_start(1'b0);
        step(4);
        tests_run++; if (dig !== 16'h5959) begin tests_failed++; $display("FAIL up_term got %h exp 5959", dig); end
        tests_run++; if ({running, done} !== 2'b01) begin tests_failed++; $display("FAIL up_done got run/done %b exp 01", {running, done}); end
        do_start(1'b0);
        step(5);
        tests_run++; if ({dig, running, done} !== {16'h5959, 2'b00}) begin tests_failed++; $display("FAIL done_start got %h/%b exp 5959/00", dig, {running, done}); end
        // start while already terminal for the sampled direction
        do_load(16'h0000);
        do_start(1'b1);
        tests_run++; if ({dig, running, done} !== {16'h0000, 2'b01}) begin tests_failed++; $display("FAIL term_start got %h/%b exp 0000/01", dig, {running, done}); end
    endtask

    task automatic test_err;
        do_load(16'h6000);
        tests_run++; if ({dig, err} !== {16'h0000, 1'b1}) begin tests_failed++; $display("FAIL err_pulse got %h/%b exp 0000/1", dig, err); end
        step(1);
        tests_run++; if (err !== 1'b0) begin tests_failed++; $display("FAIL err_one got %b exp 0", err); end
        do_load(16'h0010);
        do_start(1'b0);
        step(1);
        do_load(16'h4444);
        tests_run++; if ({dig, running, err} !== {16'h0010, 2'b10}) begin tests_failed++; $display("FAIL load_in_run got %h/%b exp 0010/10", dig, {running, err}); end
        step(2);
        tests_run++; if (dig !== 16'h0011) begin tests_failed++; $display("FAIL run_after_load got %h exp 0011", dig); end
    endtask

    task automatic test_stop_start;
        stop = 1'b1; start = 1'b1; step(1); stop = 1'b0; start = 1'b0;
        tests_run++; if (running !== 1'b0) begin tests_failed++; $display("FAIL stop_wins got %b exp 0", running); end
        step(8);
        tests_run++; if (dig !== 16'h0011) begin tests_failed++; $display("FAIL pause_hold got %h exp 0011", dig); end
        do_start(1'b1);  // direction latched on resume: down is sampled again
        tests_run++; if (running !== 1'b1) begin tests_failed++; $display("FAIL resume got %b exp 1", running); end
        step(3);
        tests_run++; if (dig !== 16'h0011) begin tests_failed++; $display("FAIL resume_hold got %h exp 0011", dig); end
        step(1);
        tests_run++; if (dig !== 16'h0010) begin tests_failed++; $display("FAIL resume_step got %h exp 0010", dig); end
        step(3);
        stop = 1'b1; step(1); stop = 1'b0;
        tests_run++; if ({dig, running} !== {16'h0010, 1'b0}) begin tests_failed++; $display("FAIL stop_on_tick got %h/%b exp 0010/0", dig, running); end
    endtask

    task automatic test_reset_mid;
        do_load(16'h1233);
        do_start(1'b0);
        step(4);
        tests_run++; if (dig !== 16'h1234) begin tests_failed++; $display("FAIL pre_reset got %h exp 1234", dig); end
        step(2);
        reset = 1'b0;
        #1;
        tests_run++; if ({dig, running, done} !== {16'h0000, 2'b00}) begin tests_failed++; $display("FAIL async_reset got %h/%b exp 0000/00", dig, {running, done}); end
        step(1);
        reset = 1'b1;
        step(6);
        tests_run++; if ({dig, running, done} !== {16'h0000, 2'b00}) begin tests_failed++; $display("FAIL post_reset got %h/%b exp 0000/00", dig, {running, done}); end
    endtask

`ifdef STOPWATCH_LAP_EN
    task automatic test_lap;
        do_start(1'b0);
        step(20);
        tests_run++; if (dig !== 16'h0005) begin tests_failed++; $display("FAIL lap_pre got %h exp 0005", dig); end
        lap = 1'b1; step(1); lap = 1'b0;
        tests_run++; if ({lapv, running} !== {16'h0005, 1'b1}) begin tests_failed++; $display("FAIL lap_cap got %h/%b exp 0005/1", lapv, running); end
        step(3);
        tests_run++; if ({dig, lapv} !== {16'h0006, 16'h0005}) begin tests_failed++; $display("FAIL lap_hold got %h/%h exp 0006/0005", dig, lapv); end
    endtask
`endif

    initial begin
        test_reset();
        test_count_down();
        test_carry();
        test_up_done();
        test_err();
        test_stop_start();
        test_reset_mid();
`ifdef STOPWATCH_LAP_EN
        test_lap();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
